// File: rtl/decimator_15.sv
// Keep-1-of-DECIMATE stage behind the 15-tap FIR: arithmetic shift, saturate to a
// narrower signed word, single registered AXI-Stream output slice with a sticky saturation flag.
`timescale 1ns/1ps
module decimator_15 #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 16,
    parameter int DECIMATE               = 4,
    parameter int SHIFT                  = 8
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_aresetn,
    input  logic                                  s00_axis_tvalid,
    input  logic                                  s00_axis_tlast,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
    output logic                                  s00_axis_tready,
    input  logic                                  m00_axis_tready,
    output logic                                  m00_axis_tvalid,
    output logic                                  m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                                  sat_flag
);
    localparam int IW = C_S00_AXIS_TDATA_WIDTH;
    localparam int OW = C_M00_AXIS_TDATA_WIDTH;
    localparam int PW = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
    localparam logic [PW-1:0] PH_MAX = PW'(DECIMATE - 1);

    logic [PW-1:0]        phase;
    logic                 out_valid;
    logic                 out_last;
    logic [OW-1:0]        out_data;
    logic                 accept;
    logic                 keep;
    logic signed [IW-1:0] t;
    logic [IW-OW:0]       hi;
    logic                 pos_sat;
    logic                 neg_sat;
    logic [OW-1:0]        scaled;
    logic                 unused_tstrb;

    assign unused_tstrb    = &{1'b0, s00_axis_tstrb};
    assign s00_axis_tready = ~out_valid | m00_axis_tready;
    assign accept          = s00_axis_tvalid & s00_axis_tready;
    // tlast forces a keep so the packet end is never swallowed by decimation
    assign keep            = accept & ((phase == '0) | s00_axis_tlast);

    // Bits from the sign down to OW-1 must all agree for t to fit in OW bits
    always_comb begin
        t       = $signed(s00_axis_tdata) >>> SHIFT;
        hi      = t[IW-1:OW-1];
        pos_sat = ~t[IW-1] & (|hi);
        neg_sat =  t[IW-1] & ~(&hi);
        if (pos_sat)
            scaled = {1'b0, {(OW-1){1'b1}}};
        else if (neg_sat)
            scaled = {1'b1, {(OW-1){1'b0}}};
        else
            scaled = t[OW-1:0];
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            phase     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            sat_flag  <= 1'b0;
        end else begin
            if (accept)
                phase <= (s00_axis_tlast || phase == PH_MAX) ? '0 : phase + 1'b1;
            if (keep) begin
                out_valid <= 1'b1;
                out_last  <= s00_axis_tlast;
                out_data  <= scaled;
                if (pos_sat || neg_sat)
                    sat_flag <= 1'b1;
            end else if (m00_axis_tready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign m00_axis_tvalid = out_valid;
    assign m00_axis_tlast  = out_last;
    assign m00_axis_tdata  = out_data;
    assign m00_axis_tstrb  = '1;
endmodule

// File: tb/tb_decimator_15.sv
// Directed bench for decimator_15: scoreboard of expected kept beats, checked at negedge.
`timescale 1ns/1ps
module tb_decimator_15;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tstrb = 4'hF;
    logic        m_tready = 1'b1, m_tvalid, m_tlast, sat_flag;
    logic [15:0] m_tdata;
    logic [1:0]  m_tstrb;

    logic        s1_tvalid = 1'b0, s1_tready, m1_tvalid, m1_tlast, sat1;
    logic [31:0] s1_tdata = '0, m1_tdata;
    logic [3:0]  m1_tstrb;

    int          checks = 0, errors = 0, npop = 0, ph = 0;
    bit          exp_sat = 0;
    logic [16:0] q[$];
    logic [31:0] q1[$];

    always #5 clk = ~clk;

    decimator_15 #(.C_S00_AXIS_TDATA_WIDTH(32), .C_M00_AXIS_TDATA_WIDTH(16),
                   .DECIMATE(4), .SHIFT(8)) dut (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
        .s00_axis_tvalid(s_tvalid), .s00_axis_tlast(s_tlast), .s00_axis_tdata(s_tdata),
        .s00_axis_tstrb(s_tstrb), .s00_axis_tready(s_tready),
        .m00_axis_tready(m_tready), .m00_axis_tvalid(m_tvalid), .m00_axis_tlast(m_tlast),
        .m00_axis_tdata(m_tdata), .m00_axis_tstrb(m_tstrb), .sat_flag(sat_flag));

    decimator_15 #(.C_S00_AXIS_TDATA_WIDTH(32), .C_M00_AXIS_TDATA_WIDTH(32),
                   .DECIMATE(1), .SHIFT(0)) dut1 (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
        .s00_axis_tvalid(s1_tvalid), .s00_axis_tlast(1'b0), .s00_axis_tdata(s1_tdata),
        .s00_axis_tstrb(4'hF), .s00_axis_tready(s1_tready),
        .m00_axis_tready(1'b1), .m00_axis_tvalid(m1_tvalid), .m00_axis_tlast(m1_tlast),
        .m00_axis_tdata(m1_tdata), .m00_axis_tstrb(m1_tstrb), .sat_flag(sat1));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] scale(input logic [31:0] d, output bit sat);
        longint t;
        t   = longint'($signed(d)) >>> 8;
        sat = 1'b0;
        if (t > 32767) begin sat = 1'b1; return 16'h7FFF; end
        if (t < -32768) begin sat = 1'b1; return 16'h8000; end
        return t[15:0];
    endfunction

    // One clock: check outputs against the scoreboard, model the accept, advance.
    task automatic cycle();
        logic        exp_rdy;
        bit          sat;
        logic [15:0] v;
        @(negedge clk);
        exp_rdy = (q.size() == 0) || m_tready;
        chk("s_tready", s_tready, exp_rdy);
        chk("m_tvalid", m_tvalid, q.size() != 0);
        chk("sat_flag", sat_flag, exp_sat);
        chk("m_tstrb", m_tstrb, 2'b11);
        if (q.size() != 0) begin
            chk("m_tdata", m_tdata, q[0][15:0]);
            chk("m_tlast", m_tlast, q[0][16]);
            if (m_tready) begin
                void'(q.pop_front());
                npop++;
            end
        end
        if (s_tvalid && exp_rdy) begin
            if (ph == 0 || s_tlast) begin
                v = scale(s_tdata, sat);
                q.push_back({s_tlast, v});
                if (sat) exp_sat = 1;
            end
            ph = (s_tlast || ph == 3) ? 0 : ph + 1;
        end
        @(posedge clk); #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        s_tvalid = 1'b1; s_tdata = d; s_tlast = last;
        cycle();
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; s_tvalid = 1'b0; s1_tvalid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete(); ph = 0; exp_sat = 0;
        chk("rst_m_tvalid", m_tvalid, 1'b0);
        chk("rst_m_tdata", m_tdata, 16'h0);
        chk("rst_m_tlast", m_tlast, 1'b0);
        chk("rst_sat_flag", sat_flag, 1'b0);
        chk("rst_s_tready", s_tready, 1'b1);
        chk("rst_m1_tvalid", m1_tvalid, 1'b0);
    endtask

    initial begin
        do_reset();

        // ramp 0x100..0x800, no tlast: expect 0x0001 and 0x0005
        for (int i = 1; i <= 8; i++) beat(32'(i * 32'h100), 1'b0);
        idle(2);
        chk("ramp_count", npop, 2);

        // saturation; tlast on each so every beat is kept
        beat(32'h0080_0000, 1'b1);
        beat(32'hFF00_0000, 1'b1);
        beat(32'hFFFF_FF00, 1'b1);
        idle(1);
        chk("sat_sticky", sat_flag, 1'b1);
        beat(32'h0000_1200, 1'b1);
        idle(2);

        // tlast mid-phase, then next beat must be kept
        npop = 0;
        beat(32'h0000_1000, 1'b0);
        beat(32'h0000_2000, 1'b0);
        beat(32'h0000_3000, 1'b1);
        beat(32'h0000_4000, 1'b0);
        idle(2);
        chk("tlast_count", npop, 3);

        // backpressure: pending output held 5 cycles, then drain + load with no gap
        idle(0); ph = ph; // phase is 1 here (0x4000 kept at phase 0)
        beat(32'h0000_0500, 1'b0);
        beat(32'h0000_0600, 1'b0);
        beat(32'h0000_0700, 1'b0);   // phase back to 0
        m_tready = 1'b0;
        beat(32'h0000_AB00, 1'b0);   // kept, then held
        s_tdata = 32'h0000_CD00; s_tlast = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        chk("bp_held_data", m_tdata, 16'h00AB);
        m_tready = 1'b1;
        cycle();                     // drains 0xAB, loads 0xCD
        idle(1);
        chk("bp_follow_data", m_tdata, 16'h00CD);
        idle(1);

        // reset while an output is pending and phase is nonzero
        beat(32'h7FFF_FFFF, 1'b0);   // saturating, kept at phase 0
        m_tready = 1'b0;
        idle(1);
        do_reset();
        m_tready = 1'b1;
        beat(32'h0000_2200, 1'b0);   // first beat after reset must be kept
        idle(2);

        // DECIMATE=1, SHIFT=0, 32-bit output: pass-through at one beat per cycle
        s1_tvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s1_tdata = $urandom;
            q1.push_back(s1_tdata);
            @(posedge clk); #1;
            chk("d1_s_tready", s1_tready, 1'b1);
            chk("d1_m_tvalid", m1_tvalid, 1'b1);
            chk("d1_m_tdata", m1_tdata, q1.pop_front());
        end
        s1_tvalid = 1'b0;
        @(posedge clk); #1;
        chk("d1_drained", m1_tvalid, 1'b0);
        chk("d1_sat", sat1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
